// File: rtl/reaction_timer_core_if.sv
// Bus between the reaction-timer core and its surroundings: divided tick, buttons,
// BCD count and status flags. The master side drives the buttons and sclk.
interface reaction_timer_core_if;
  logic        sclk;
  logic        start;
  logic        stop;
  logic [15:0] digits;
  logic        led_go;
  logic        early;
  logic        timeout;
  logic        busy;

  modport master (
    output sclk, start, stop,
    input  digits, led_go, early, timeout, busy
  );

  modport slave (
    input  sclk, start, stop,
    output digits, led_go, early, timeout, busy
  );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction-timer control: pseudo-random wait, then GO, then millisecond counting in
// four BCD digits until stop, early press, or saturation at 9999.
module reaction_timer_core #(
  parameter int unsigned MIN_WAIT  = 1000,
  parameter int unsigned WAIT_BITS = 12,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input logic                   clk,
  input logic                   reset,
  reaction_timer_core_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_EARLY
  } state_e;

  state_e                 state_q, state_d;
  logic [WAIT_BITS-1:0]   wcnt_q, wcnt_d;
  logic [15:0]            digits_q, digits_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic                   sclk_q, start_q, stop_q;

  logic                   tick, start_e, stop_e;
  logic [WAIT_BITS-1:0]   wait_load;

  // Ripple-carry BCD increment; a digit wraps 9->0 only when all lower digits wrap.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick    = bus.sclk  & ~sclk_q;
  assign start_e = bus.start & ~start_q;
  assign stop_e  = bus.stop  & ~stop_q;

  // Taps x^8+x^6+x^5+x^4+1 map to bits 7,5,4,3 of a left-shifting register.
  assign lfsr_d    = {lfsr_q[6:0], ^(lfsr_q & 8'hB8)};
  assign wait_load = WAIT_BITS'(MIN_WAIT) + WAIT_BITS'({lfsr_q, 2'b00});

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    digits_d  = digits_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_EARLY: begin
        // Start outranks a simultaneous stop in every resting state.
        if (start_e) begin
          state_d   = S_WAIT;
          digits_d  = '0;
          timeout_d = 1'b0;
          wcnt_d    = wait_load;
        end
      end

      S_WAIT: begin
        if (stop_e) begin
          state_d = S_EARLY;
        end else if (tick) begin
          if (wcnt_q == WAIT_BITS'(1)) state_d = S_GO;
          else                         wcnt_d  = wcnt_q - WAIT_BITS'(1);
        end
      end

      S_GO: begin
        if (stop_e) begin
          state_d = S_DONE;
        end else if (tick) begin
          if (digits_q == 16'h9999) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            digits_d = bcd_inc(digits_q);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      digits_q  <= '0;
      timeout_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      sclk_q    <= 1'b0;
      start_q   <= 1'b1;
      stop_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      digits_q  <= digits_d;
      timeout_q <= timeout_d;
      lfsr_q    <= lfsr_d;
      sclk_q    <= bus.sclk;
      start_q   <= bus.start;
      stop_q    <= bus.stop;
    end
  end

  assign bus.digits  = digits_q;
  assign bus.led_go  = (state_q == S_GO);
  assign bus.early   = (state_q == S_EARLY);
  assign bus.timeout = timeout_q;
  assign bus.busy    = (state_q == S_WAIT) || (state_q == S_GO);

  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!reset) lfsr_q != 8'h00);

  a_digits_bcd: assert property (@(posedge clk) disable iff (!reset)
    (digits_q[3:0] <= 4'd9) && (digits_q[7:4] <= 4'd9) &&
    (digits_q[11:8] <= 4'd9) && (digits_q[15:12] <= 4'd9));

  a_timeout_only_done: assert property (@(posedge clk) disable iff (!reset)
    timeout_q |-> (state_q == S_DONE));

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench: an integer/millisecond model of the reaction timer is compared
// against the core every cycle, plus directed literal checks at key points.
module tb_reaction_timer_core;

  localparam int MIN_WAIT = 3;

  logic clk;
  logic reset;
  reaction_timer_core_if bus ();

  reaction_timer_core #(
    .MIN_WAIT (MIN_WAIT),
    .WAIT_BITS(12),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase names, elapsed ms as a plain integer, remaining wait ticks as an integer.
  localparam int P_IDLE = 0, P_WAIT = 1, P_GO = 2, P_DONE = 3, P_EARLY = 4;
  int         m_phase;
  int         m_ms;
  int         m_left;
  int         m_load;
  bit         m_to;
  logic [7:0] m_lfsr;
  logic       m_prev_sclk, m_prev_start, m_prev_stop;
  bit         m_tick, m_start_e, m_stop_e;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase      = P_IDLE;
      m_ms         = 0;
      m_left       = 0;
      m_to         = 0;
      m_lfsr       = 8'hA5;
      m_prev_sclk  = 1'b0;
      m_prev_start = 1'b1;
      m_prev_stop  = 1'b1;
    end else begin
      m_tick    = bus.sclk  && !m_prev_sclk;
      m_start_e = bus.start && !m_prev_start;
      m_stop_e  = bus.stop  && !m_prev_stop;
      if (m_phase inside {P_IDLE, P_DONE, P_EARLY}) begin
        if (m_start_e) begin
          m_phase = P_WAIT;
          m_ms    = 0;
          m_to    = 0;
          m_left  = MIN_WAIT + 4 * int'(m_lfsr);
          m_load  = m_left;
        end
      end else if (m_phase == P_WAIT) begin
        if (m_stop_e) m_phase = P_EARLY;
        else if (m_tick) begin
          m_left--;
          if (m_left == 0) m_phase = P_GO;
        end
      end else if (m_phase == P_GO) begin
        if (m_stop_e) m_phase = P_DONE;
        else if (m_tick) begin
          if (m_ms == 9999) begin
            m_phase = P_DONE;
            m_to    = 1;
          end else begin
            m_ms++;
          end
        end
      end
      m_lfsr       = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_prev_sclk  = bus.sclk;
      m_prev_start = bus.start;
      m_prev_stop  = bus.stop;
    end
  end

  function automatic logic [31:0] dut_vec();
    return {12'h0, bus.digits, bus.led_go, bus.early, bus.timeout, bus.busy};
  endfunction

  function automatic logic [31:0] model_vec();
    return {12'h0, to_bcd(m_ms), m_phase == P_GO, m_phase == P_EARLY, m_to,
            m_phase == P_WAIT || m_phase == P_GO};
  endfunction

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en && reset) check("cycle_model", dut_vec(), model_vec());
  end

  // Each task begins by waiting for a falling edge; its effect is visible on return.
  task automatic do_tick();
    @(negedge clk) bus.sclk = 1'b1;
    @(negedge clk) bus.sclk = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic press_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic press_stop();
    @(negedge clk) bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
  endtask

  task automatic tick_with_stop();
    @(negedge clk) begin bus.sclk = 1'b1; bus.stop = 1'b1; end
    @(negedge clk) begin bus.sclk = 1'b0; bus.stop = 1'b0; end
  endtask

  task automatic tick_until_go(output int n);
    n = 0;
    while (!bus.led_go && n < 1100) begin
      do_tick();
      n++;
    end
    if (!bus.led_go) check("go_wait_bound", 32'(bus.led_go), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_go;
    int load;

    bus.sclk  = 1'b0;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    reset     = 1'b0;

    // Reset held with start high, then released with start still high.
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), 32'h0);
    reset  = 1'b1;
    cmp_en = 1;
    repeat (4) @(negedge clk);
    check("idle_after_release", dut_vec(), 32'h0);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // Normal run: GO after exactly MIN_WAIT+4L ticks, stop after 137 ms.
    press_start();
    check("wait_busy", dut_vec(), {12'h0, 16'h0000, 4'b0001});
    load = m_load;
    tick_until_go(n_go);
    check("go_after_ticks", 32'(n_go), 32'(MIN_WAIT + 4 * ((load - MIN_WAIT) / 4)));
    ticks(137);
    check("go_0137", dut_vec(), {12'h0, 16'h0137, 4'b1001});
    press_stop();
    check("done_0137", dut_vec(), {12'h0, 16'h0137, 4'b0000});

    // Carry chains, then saturation to 9999 and timeout.
    press_start();
    tick_until_go(n_go);
    ticks(99);
    check("bcd_0099", 32'(bus.digits), 32'h0099);
    do_tick();
    check("bcd_0100", 32'(bus.digits), 32'h0100);
    ticks(899);
    check("bcd_0999", 32'(bus.digits), 32'h0999);
    do_tick();
    check("bcd_1000", 32'(bus.digits), 32'h1000);
    ticks(8999);
    check("bcd_9999_go", dut_vec(), {12'h0, 16'h9999, 4'b1001});
    do_tick();
    check("saturated_done", dut_vec(), {12'h0, 16'h9999, 4'b0010});
    do_tick();
    check("saturated_hold", dut_vec(), {12'h0, 16'h9999, 4'b0010});
    press_start();
    check("timeout_cleared", dut_vec(), {12'h0, 16'h0000, 4'b0001});

    // Early stop during WAIT, then restart.
    ticks(2);
    press_stop();
    check("early_set", dut_vec(), {12'h0, 16'h0000, 4'b0100});
    press_start();
    check("early_cleared", dut_vec(), {12'h0, 16'h0000, 4'b0001});

    // Tick and stop on the same clock with one wait tick left: stop wins.
    ticks(m_load - 1);
    check("wait_one_left", 32'(m_left), 32'd1);
    tick_with_stop();
    check("wait_collision", dut_vec(), {12'h0, 16'h0000, 4'b0100});

    // Tick and stop on the same clock in GO at 0049: count frozen.
    press_start();
    tick_until_go(n_go);
    ticks(49);
    check("go_0049", dut_vec(), {12'h0, 16'h0049, 4'b1001});
    tick_with_stop();
    check("go_collision", dut_vec(), {12'h0, 16'h0049, 4'b0000});

    // Start and stop together in DONE: start wins.
    @(negedge clk) begin bus.start = 1'b1; bus.stop = 1'b1; end
    @(negedge clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
    check("start_beats_stop", dut_vec(), {12'h0, 16'h0000, 4'b0001});

    // Asynchronous reset in the middle of WAIT, then in the middle of GO.
    ticks(1);
    @(negedge clk) reset = 1'b0;
    #1 check("reset_mid_wait", dut_vec(), 32'h0);
    @(negedge clk) reset = 1'b1;
    press_start();
    tick_until_go(n_go);
    ticks(25);
    check("go_0025", 32'(bus.digits), 32'h0025);
    @(negedge clk) reset = 1'b0;
    #1 check("reset_mid_go", dut_vec(), 32'h0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", dut_vec(), 32'h0);

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
